// File: rtl/cmos_cfg_pkg.sv
// Shared definitions for the CMOS sensor configuration sequencer:
// table entry type codes, sequencer state encoding and entry width helper.
package cmos_cfg_pkg;

    typedef enum logic [1:0] {
        ENT_WRITE = 2'd0,
        ENT_DELAY = 2'd1,
        ENT_END   = 2'd2,
        ENT_RSVD  = 2'd3
    } entry_type_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    // Entry layout is {type[1:0], reg_addr[8*addr_bytes-1:0], data[7:0]}.
    function automatic int entry_w(input int addr_bytes);
        return 2 + 8 * addr_bytes + 8;
    endfunction

endpackage

// File: rtl/cmos_cfg_seq_if.sv
// Request/completion handshake between the configuration sequencer and an IIC master.
interface cmos_cfg_seq_if #(
    parameter int ADDR_BYTES = 2
);
    logic                    iic_write;
    logic                    iic_read;
    logic [8*ADDR_BYTES-1:0] iic_addr;
    logic [7:0]              iic_wdata;
    logic [7:0]              iic_rdata;
    logic                    iic_wr_done;
    logic                    iic_rd_done;
    logic                    iic_nack;

    modport master (
        output iic_write, iic_read, iic_addr, iic_wdata,
        input  iic_rdata, iic_wr_done, iic_rd_done, iic_nack
    );

    modport slave (
        input  iic_write, iic_read, iic_addr, iic_wdata,
        output iic_rdata, iic_wr_done, iic_rd_done, iic_nack
    );
endinterface

// File: rtl/cfg_delay_timer.sv
// Two-level down counter: expire pulses after units * DELAY_TICK cycles from load.
// units == 0 never arms the timer; the sequencer skips such delays itself.
module cfg_delay_timer #(
    parameter int DELAY_TICK = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] units,
    output logic       expire
);
    localparam int TICK_W = (DELAY_TICK > 1) ? $clog2(DELAY_TICK) : 1;

    logic              active_q;
    logic [TICK_W-1:0] tick_q;
    logic [7:0]        unit_q;
    logic              tick_wrap;

    assign tick_wrap = (tick_q == '0);
    assign expire    = active_q && tick_wrap && (unit_q == 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            tick_q   <= '0;
            unit_q   <= '0;
        end else if (load) begin
            active_q <= (units != 8'd0);
            tick_q   <= TICK_W'(DELAY_TICK - 1);
            unit_q   <= units;
        end else if (active_q) begin
            if (tick_wrap) begin
                if (unit_q == 8'd1) begin
                    active_q <= 1'b0;
                end else begin
                    unit_q <= unit_q - 8'd1;
                    tick_q <= TICK_W'(DELAY_TICK - 1);
                end
            end else begin
                tick_q <= tick_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmos_cfg_seq.sv
// Walks a register table in ROM and drives an IIC master to configure a CMOS sensor,
// with optional read-back verification, bounded retries and millisecond delays.
module cmos_cfg_seq
    import cmos_cfg_pkg::*;
#(
    parameter int  ADDR_BYTES = 2,
    parameter int  DEPTH      = 256,
    parameter int  VERIFY     = 1,
    parameter int  MAX_RETRY  = 3,
    parameter int  DELAY_TICK = 50000,
    parameter int  AUTO_START = 1,
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int ENTRY_W    = entry_w(ADDR_BYTES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [IDX_W-1:0]   rom_addr,
    input  logic [ENTRY_W-1:0] rom_data,
    cmos_cfg_seq_if.master     iic,
    output logic               busy,
    output logic               config_done,
    output logic               config_err,
    output logic [IDX_W-1:0]   err_index
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    cfg_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              auto_q, auto_d;
    logic              advance, fail;
    logic              tmr_load, tmr_expire;
    logic              last_idx;

    entry_type_e       ent_type;
    logic [ADDR_W-1:0] ent_addr;
    logic [7:0]        ent_data;

    assign ent_type = entry_type_e'(rom_data[ENTRY_W-1 -: 2]);
    assign ent_addr = rom_data[8 +: ADDR_W];
    assign ent_data = rom_data[7:0];
    assign last_idx = (idx_q == IDX_W'(DEPTH - 1));

    cfg_delay_timer #(
        .DELAY_TICK(DELAY_TICK)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .units  (ent_data),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            err_idx_q <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            auto_q    <= (AUTO_START != 0);
        end else begin
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            auto_q    <= auto_d;
        end
        rdata_q <= rdata_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        retry_d   = retry_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rdata_d   = rdata_q;
        auto_d    = auto_q;
        tmr_load  = 1'b0;
        advance   = 1'b0;
        fail      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start || auto_q) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                    auto_d  = 1'b0;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (ent_type)
                    ENT_WRITE: begin
                        addr_d  = ent_addr;
                        data_d  = ent_data;
                        state_d = ST_WR_REQ;
                    end
                    ENT_DELAY: begin
                        if (ent_data == 8'd0) begin
                            advance = 1'b1;
                        end else begin
                            tmr_load = 1'b1;
                            state_d  = ST_DELAY;
                        end
                    end
                    ENT_END:   state_d = ST_DONE;
                    default:   advance = 1'b1;
                endcase
            end
            ST_WR_REQ: state_d = ST_WR_WAIT;
            ST_WR_WAIT: begin
                // A NACK wins over a coincident done strobe.
                if (iic.iic_nack) begin
                    fail = 1'b1;
                end else if (iic.iic_wr_done) begin
                    if (VERIFY != 0) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_RD_REQ: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (iic.iic_nack) begin
                    fail = 1'b1;
                end else if (iic.iic_rd_done) begin
                    rdata_d = iic.iic_rdata;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rdata_q == data_q) begin
                    advance = 1'b1;
                end else begin
                    fail = 1'b1;
                end
            end
            ST_DELAY: begin
                if (tmr_expire) begin
                    advance = 1'b1;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The table never wraps: finishing the last slot ends the run.
        if (advance) begin
            retry_d = '0;
            if (last_idx) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_FETCH;
            end
        end

        if (fail) begin
            if (int'(retry_q) < MAX_RETRY) begin
                retry_d = retry_q + 1'b1;
                state_d = ST_WR_REQ;
            end else begin
                err_idx_d = idx_q;
                state_d   = ST_ERROR;
            end
        end
    end

    assign rom_addr      = idx_q;
    assign iic.iic_write = (state_q == ST_WR_REQ);
    assign iic.iic_read  = (state_q == ST_RD_REQ);
    assign iic.iic_addr  = addr_q;
    assign iic.iic_wdata = data_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERROR);
    assign config_done   = (state_q == ST_DONE);
    assign config_err    = (state_q == ST_ERROR);
    assign err_index     = err_idx_q;

endmodule
